// File: rtl/bus_err_logger_pkg.sv
// Shared definitions for bus_err_logger: register offsets and the bit
// positions of the LOG_INFO and STATUS read words.
package bus_err_logger_pkg;

  typedef enum logic [3:0] {
    REG_LOG_ADDR    = 4'd0,
    REG_LOG_INFO    = 4'd1,
    REG_LOG_POP     = 4'd2,
    REG_TIMEOUT_CNT = 4'd3,
    REG_MEMV_CNT    = 4'd4,
    REG_IRQ_MASK    = 4'd5,
    REG_STATUS      = 4'd6,
    REG_STATUS_CLR  = 4'd7
  } reg_off_e;

  // LOG_INFO = {zeros, we, id, timeout, memv}
  localparam int unsigned INFO_MEMV_BIT    = 0;
  localparam int unsigned INFO_TIMEOUT_BIT = 1;
  localparam int unsigned INFO_ID_LSB      = 2;

  // STATUS = {zeros, level[6:0], overflow, full, empty}
  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_LEVEL_LSB = 3;
  localparam int unsigned ST_LEVEL_W   = 7;

endpackage

// File: rtl/bus_err_logger_fifo.sv
// err_log_fifo: first-word-fall-through FIFO holding logged bus errors.
// Ports: clk/rst (sync, active-high), push/din, pop, dout (head, combinational),
// level (0..DEPTH), full, empty.
// Pop on empty is ignored; push on full succeeds only with a same-cycle pop.
module err_log_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; only slots below level are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_err_logger.sv
// bus_err_logger: Wishbone slave that logs arbiter error strobes into a FIFO
// and counts timeout / memory-violation events.
// Ports: wb_* Wishbone slave (single-cycle registered ack), bm_* error strobes
// and attributes of the failing access, irq_o level interrupt.
module bus_err_logger
  import bus_err_logger_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 8,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [15:0]     wb_adr_i,
  input  logic [15:0]     wb_dat_i,
  output logic [15:0]     wb_dat_o,
  output logic            wb_ack_o,
  input  logic            bm_memv,
  input  logic            bm_timeout,
  input  logic [ID_W-1:0] bm_wbm_id,
  input  logic [15:0]     bm_addr,
  input  logic            bm_we,
  output logic            irq_o
);

  localparam int unsigned INFO_W = ID_W + 3;
  localparam int unsigned EW     = 16 + INFO_W;
  localparam int unsigned LW     = $clog2(LOG_DEPTH) + 1;

  logic             ack_q, ack_d;
  logic [15:0]      dat_q, dat_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;
  logic             mask_q, mask_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] mv_cnt_q, mv_cnt_d;

  logic             accept, wr;
  logic [3:0]       sel;
  logic             pop, to_clr, mv_clr, ovf_clr, mask_wr;
  logic             ev_push, ovf_set;
  logic [EW-1:0]    entry, head;
  logic [LW-1:0]    level;
  logic             full, empty;
  logic [15:0]      status, rdata;

  logic unused_inputs;
  assign unused_inputs = ^{wb_adr_i[15:4], wb_dat_i[15:1]};

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic clr, input logic inc);
    if (clr)           return inc ? CNT_W'(1) : '0;
    else if (inc && c != '1) return c + CNT_W'(1);
    else               return c;
  endfunction

  assign accept = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr     = accept & wb_we_i;
  assign sel    = wb_adr_i[3:0];

  always_comb begin
    pop     = wr && (sel == REG_LOG_POP);
    to_clr  = wr && (sel == REG_TIMEOUT_CNT);
    mv_clr  = wr && (sel == REG_MEMV_CNT);
    mask_wr = wr && (sel == REG_IRQ_MASK);
    ovf_clr = wr && (sel == REG_STATUS_CLR);
  end

  assign entry   = {bm_addr, bm_we, bm_wbm_id, bm_timeout, bm_memv};
  assign ev_push = bm_memv | bm_timeout;
  // full implies non-empty, so a same-cycle pop always frees a slot
  assign ovf_set = ev_push & full & ~pop;

  err_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (ev_push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    status = '0;
    status[ST_EMPTY_BIT] = empty;
    status[ST_FULL_BIT]  = full;
    status[ST_OVF_BIT]   = ovf_q;
    status[ST_LEVEL_LSB +: LW] = level;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_LOG_ADDR:    if (!empty) rdata = head[EW-1 -: 16];
      REG_LOG_INFO:    if (!empty) rdata[INFO_W-1:0] = head[INFO_W-1:0];
      REG_TIMEOUT_CNT: rdata[CNT_W-1:0] = to_cnt_q;
      REG_MEMV_CNT:    rdata[CNT_W-1:0] = mv_cnt_q;
      REG_IRQ_MASK:    rdata[0] = mask_q;
      REG_STATUS:      rdata = status;
      default:         rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = accept;
    dat_d    = (accept && !wb_we_i) ? rdata : '0;
    mask_d   = mask_wr ? wb_dat_i[0] : mask_q;
    // a new overflow in the clearing cycle is kept
    ovf_d    = (ovf_q & ~ovf_clr) | ovf_set;
    to_cnt_d = cnt_next(to_cnt_q, to_clr, bm_timeout);
    mv_cnt_d = cnt_next(mv_cnt_q, mv_clr, bm_memv);
    irq_d    = mask_q & (~empty | ovf_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      mask_q   <= 1'b0;
      to_cnt_q <= '0;
      mv_cnt_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      mask_q   <= mask_d;
      to_cnt_q <= to_cnt_d;
      mv_cnt_q <= mv_cnt_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule
